// File: rtl/decode_top_if.sv
// decode_top_if: fetch, writeback, control and ALU-request signals of the decode stage
interface decode_top_if #(
    parameter int DATA_W = 32
);
    logic              fetch_valid;
    logic [31:0]       fetch_instr;
    logic [DATA_W-1:0] fetch_pc;
    logic              decode_busy;
    logic              stall_decode;
    logic              flush_decode;
    logic              rf_wr_en;
    logic [4:0]        rf_wr_addr;
    logic [DATA_W-1:0] rf_wr_data;
    logic              req_alu_valid;
    logic [6:0]        req_alu_opcode;
    logic [4:0]        req_alu_rd_addr;
    logic [4:0]        req_alu_ra_addr;
    logic [4:0]        req_alu_rb_addr;
    logic [DATA_W-1:0] req_alu_ra_data;
    logic [DATA_W-1:0] req_alu_rb_data;
    logic [31:0]       req_alu_offset;
    logic [DATA_W-1:0] req_alu_pc;
    logic              xcpt_illegal;
    logic [DATA_W-1:0] xcpt_pc;

    modport master (
        output fetch_valid, fetch_instr, fetch_pc, stall_decode, flush_decode,
        output rf_wr_en, rf_wr_addr, rf_wr_data,
        input  decode_busy, req_alu_valid, req_alu_opcode, req_alu_rd_addr,
        input  req_alu_ra_addr, req_alu_rb_addr, req_alu_ra_data, req_alu_rb_data,
        input  req_alu_offset, req_alu_pc, xcpt_illegal, xcpt_pc
    );

    modport slave (
        input  fetch_valid, fetch_instr, fetch_pc, stall_decode, flush_decode,
        input  rf_wr_en, rf_wr_addr, rf_wr_data,
        output decode_busy, req_alu_valid, req_alu_opcode, req_alu_rd_addr,
        output req_alu_ra_addr, req_alu_rb_addr, req_alu_ra_data, req_alu_rb_data,
        output req_alu_offset, req_alu_pc, xcpt_illegal, xcpt_pc
    );
endinterface

// File: rtl/decode_top.sv
// decode_top: decode stage with register file, pending scoreboard and registered ALU request
`ifndef INSTR_ADD_OPCODE
`define INSTR_ADD_OPCODE  7'h00
`define INSTR_SUB_OPCODE  7'h01
`define INSTR_MUL_OPCODE  7'h02
`define INSTR_ADDI_OPCODE 7'h03
`define INSTR_LDB_OPCODE  7'h10
`define INSTR_LDW_OPCODE  7'h11
`define INSTR_STB_OPCODE  7'h12
`define INSTR_STW_OPCODE  7'h13
`define INSTR_BEQ_OPCODE  7'h30
`define INSTR_BNE_OPCODE  7'h31
`define INSTR_BLT_OPCODE  7'h32
`define INSTR_BGT_OPCODE  7'h33
`define INSTR_BLE_OPCODE  7'h34
`define INSTR_BGE_OPCODE  7'h35
`define INSTR_JUMP_OPCODE 7'h40
`endif

module decode_top #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input logic         clock,
    input logic         reset,
    decode_top_if.slave bus
);
    logic [6:0]        opcode;
    logic              is_r, is_i, is_s, is_b, is_j, legal;
    logic              writes_rd, use_a, use_b;
    logic [4:0]        rd, ra, rb;
    logic [31:0]       offset;
    logic [31:0]       pending, clr_mask, set_mask;
    logic              hazard, accept;
    logic [DATA_W-1:0] ra_data, rb_data;
    logic [DATA_W-1:0] rf [NREGS];

    assign opcode = bus.fetch_instr[31:25];
    assign is_r   = opcode == `INSTR_ADD_OPCODE || opcode == `INSTR_SUB_OPCODE ||
                    opcode == `INSTR_MUL_OPCODE;
    assign is_i   = opcode == `INSTR_ADDI_OPCODE || opcode == `INSTR_LDB_OPCODE ||
                    opcode == `INSTR_LDW_OPCODE;
    assign is_s   = opcode == `INSTR_STB_OPCODE || opcode == `INSTR_STW_OPCODE;
    assign is_b   = opcode == `INSTR_BEQ_OPCODE || opcode == `INSTR_BNE_OPCODE ||
                    opcode == `INSTR_BLT_OPCODE || opcode == `INSTR_BGT_OPCODE ||
                    opcode == `INSTR_BLE_OPCODE || opcode == `INSTR_BGE_OPCODE;
    assign is_j   = opcode == `INSTR_JUMP_OPCODE;
    assign legal  = is_r | is_i | is_s | is_b | is_j;

    // Field extraction: fields a format does not define decode as zero
    assign writes_rd = is_r | is_i;
    assign use_a     = is_r | is_i | is_s | is_b;
    assign use_b     = is_r | is_s | is_b;
    assign rd        = writes_rd ? bus.fetch_instr[24:20] : 5'd0;
    assign ra        = writes_rd ? bus.fetch_instr[19:15] :
                       (is_s | is_b) ? bus.fetch_instr[24:20] : 5'd0;
    assign rb        = is_r ? bus.fetch_instr[14:10] :
                       (is_s | is_b) ? bus.fetch_instr[19:15] : 5'd0;
    assign offset    = is_j ? {7'd0, bus.fetch_instr[24:0]} :
                       (is_i | is_s | is_b) ? {17'd0, bus.fetch_instr[14:0]} : 32'd0;

    // Operand read with write-through of the same-cycle writeback; r0 is hard zero
    assign ra_data = (ra == 5'd0) ? '0 :
                     (bus.rf_wr_en && bus.rf_wr_addr == ra) ? bus.rf_wr_data : rf[ra];
    assign rb_data = (rb == 5'd0) ? '0 :
                     (bus.rf_wr_en && bus.rf_wr_addr == rb) ? bus.rf_wr_data : rf[rb];

    // Sources may use a same-cycle writeback; a pending rd (WAW) always stalls
    assign clr_mask = bus.rf_wr_en ? (32'd1 << bus.rf_wr_addr) : 32'd0;
    assign hazard   = bus.fetch_valid &
                      ((use_a & pending[ra] & ~clr_mask[ra]) |
                       (use_b & pending[rb] & ~clr_mask[rb]) |
                       (writes_rd & pending[rd]));
    assign bus.decode_busy = bus.stall_decode | hazard;
    assign accept   = bus.fetch_valid & ~bus.decode_busy & ~bus.flush_decode;
    assign set_mask = (accept && writes_rd && rd != 5'd0) ? (32'd1 << rd) : 32'd0;

    // Register file: writeback port, r0 never written
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (bus.rf_wr_en && bus.rf_wr_addr != 5'd0) begin
            rf[bus.rf_wr_addr] <= bus.rf_wr_data;
        end
    end

    // Scoreboard: set by an accepted writer wins over a writeback clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) pending <= '0;
        else        pending <= (pending & ~clr_mask) | set_mask;
    end

    // ALU request and exception registers: flush kills, stall freezes, else load or bubble
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.req_alu_valid   <= 1'b0;
            bus.req_alu_opcode  <= '0;
            bus.req_alu_rd_addr <= '0;
            bus.req_alu_ra_addr <= '0;
            bus.req_alu_rb_addr <= '0;
            bus.req_alu_ra_data <= '0;
            bus.req_alu_rb_data <= '0;
            bus.req_alu_offset  <= '0;
            bus.req_alu_pc      <= '0;
            bus.xcpt_illegal    <= 1'b0;
            bus.xcpt_pc         <= '0;
        end else if (bus.flush_decode) begin
            bus.req_alu_valid <= 1'b0;
            bus.xcpt_illegal  <= 1'b0;
        end else if (!bus.stall_decode) begin
            bus.req_alu_valid <= accept & legal;
            bus.xcpt_illegal  <= accept & ~legal;
            if (accept && legal) begin
                bus.req_alu_opcode  <= opcode;
                bus.req_alu_rd_addr <= rd;
                bus.req_alu_ra_addr <= ra;
                bus.req_alu_rb_addr <= rb;
                bus.req_alu_ra_data <= ra_data;
                bus.req_alu_rb_data <= rb_data;
                bus.req_alu_offset  <= offset;
                bus.req_alu_pc      <= bus.fetch_pc;
            end
            if (accept && !legal) bus.xcpt_pc <= bus.fetch_pc;
        end
    end
endmodule

// File: tb/tb_decode_top.sv
// tb_decode_top: table vectors, directed corner sequences and randomized run against a reference model
module tb_decode_top;
    localparam logic [6:0] OP_ADD = 7'h00, OP_SUB = 7'h01, OP_MUL = 7'h02, OP_ADDI = 7'h03;
    localparam logic [6:0] OP_LDB = 7'h10, OP_LDW = 7'h11, OP_STB = 7'h12, OP_STW = 7'h13;
    localparam logic [6:0] OP_BEQ = 7'h30, OP_BNE = 7'h31, OP_BLT = 7'h32, OP_BGT = 7'h33;
    localparam logic [6:0] OP_BLE = 7'h34, OP_BGE = 7'h35, OP_JUMP = 7'h40;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    decode_top_if #(.DATA_W(32)) bus ();
    decode_top #(.DATA_W(32), .NREGS(32)) dut (.clock(clock), .reset(reset), .bus(bus));

    typedef struct packed {
        logic        v;
        logic [6:0]  op;
        logic [4:0]  rd, ra, rb;
        logic [31:0] ad, bd, off, pc;
        logic        x;
        logic [31:0] xpc;
    } out_t;

    typedef struct packed {
        logic        legal, wr, ua, ub;
        logic [4:0]  rd, ra, rb;
        logic [31:0] off;
    } dec_t;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  f1, f2;
        logic [14:0] f3;
        logic        v;
        logic [4:0]  rd, ra, rb;
        logic [31:0] off;
        logic        x;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    logic [31:0] m_rf [32];
    bit          m_pend [32];
    out_t        m_o;
    bit          m_busy;
    vec_t        tbl [13];
    logic [6:0]  ops [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic dec_t dec(input logic [31:0] i);
        dec_t d = '0;
        d.legal = 1'b1;
        case (i[31:25])
            OP_ADD, OP_SUB, OP_MUL: begin
                d.wr = 1; d.ua = 1; d.ub = 1;
                d.rd = i[24:20]; d.ra = i[19:15]; d.rb = i[14:10];
            end
            OP_ADDI, OP_LDB, OP_LDW: begin
                d.wr = 1; d.ua = 1;
                d.rd = i[24:20]; d.ra = i[19:15]; d.off = 32'(i[14:0]);
            end
            OP_STB, OP_STW, OP_BEQ, OP_BNE, OP_BLT, OP_BGT, OP_BLE, OP_BGE: begin
                d.ua = 1; d.ub = 1;
                d.ra = i[24:20]; d.rb = i[19:15]; d.off = 32'(i[14:0]);
            end
            OP_JUMP: d.off = 32'(i[24:0]);
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] rdv(input logic [4:0] r);
        if (r == 0) return 32'd0;
        if (bus.rf_wr_en && bus.rf_wr_addr == r) return bus.rf_wr_data;
        return m_rf[r];
    endfunction

    function automatic bit wb_hits(input logic [4:0] r);
        return bus.rf_wr_en && bus.rf_wr_addr == r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_rf[i] = 0;
            m_pend[i] = 0;
        end
        m_o = '0;
    endtask

    task automatic compare_outs(input string tag);
        chk({tag, ".valid"}, bus.req_alu_valid, m_o.v);
        chk({tag, ".opcode"}, bus.req_alu_opcode, m_o.op);
        chk({tag, ".rd"}, bus.req_alu_rd_addr, m_o.rd);
        chk({tag, ".ra"}, bus.req_alu_ra_addr, m_o.ra);
        chk({tag, ".rb"}, bus.req_alu_rb_addr, m_o.rb);
        chk({tag, ".ra_data"}, bus.req_alu_ra_data, m_o.ad);
        chk({tag, ".rb_data"}, bus.req_alu_rb_data, m_o.bd);
        chk({tag, ".offset"}, bus.req_alu_offset, m_o.off);
        chk({tag, ".pc"}, bus.req_alu_pc, m_o.pc);
        chk({tag, ".xcpt"}, bus.xcpt_illegal, m_o.x);
        chk({tag, ".xcpt_pc"}, bus.xcpt_pc, m_o.xpc);
    endtask

    task automatic step(input string tag);
        dec_t d;
        bit   haz, acc;
        out_t n;
        #1;
        d = dec(bus.fetch_instr);
        haz = bus.fetch_valid &&
              ((d.ua && m_pend[d.ra] && !wb_hits(d.ra)) ||
               (d.ub && m_pend[d.rb] && !wb_hits(d.rb)) ||
               (d.wr && m_pend[d.rd]));
        m_busy = bus.stall_decode || haz;
        chk({tag, ".busy"}, bus.decode_busy, m_busy);
        acc = bus.fetch_valid && !m_busy && !bus.flush_decode;
        n = m_o;
        if (bus.flush_decode) begin
            n.v = 0;
            n.x = 0;
        end else if (!bus.stall_decode) begin
            n.v = acc && d.legal;
            n.x = acc && !d.legal;
            if (acc && d.legal) begin
                n.op = bus.fetch_instr[31:25];
                n.rd = d.rd; n.ra = d.ra; n.rb = d.rb;
                n.ad = rdv(d.ra); n.bd = rdv(d.rb);
                n.off = d.off; n.pc = bus.fetch_pc;
            end
            if (acc && !d.legal) n.xpc = bus.fetch_pc;
        end
        if (bus.rf_wr_en) begin
            if (bus.rf_wr_addr != 0) m_rf[bus.rf_wr_addr] = bus.rf_wr_data;
            m_pend[bus.rf_wr_addr] = 0;
        end
        if (acc && d.wr && d.rd != 0) m_pend[d.rd] = 1;
        m_o = n;
        @(posedge clock);
        #1;
        compare_outs(tag);
    endtask

    task automatic idle();
        bus.fetch_valid = 0; bus.fetch_instr = 0; bus.fetch_pc = 0;
        bus.stall_decode = 0; bus.flush_decode = 0;
        bus.rf_wr_en = 0; bus.rf_wr_addr = 0; bus.rf_wr_data = 0;
    endtask

    task automatic do_reset();
        reset = 0;
        #1;
        model_clear();
        compare_outs("rst");
        chk("rst.busy", bus.decode_busy, bus.stall_decode);
        @(posedge clock);
        #1;
        reset = 1;
    endtask

    task automatic fetch(input logic [31:0] instr, input logic [31:0] pc);
        bus.fetch_valid = 1;
        bus.fetch_instr = instr;
        bus.fetch_pc = pc;
    endtask

    initial begin
        logic [31:0] pc;
        bit          hold;
        ops = '{OP_ADD, OP_SUB, OP_MUL, OP_ADDI, OP_LDB, OP_LDW, OP_STB, OP_STW,
                OP_BEQ, OP_BNE, OP_BLT, OP_BGT, OP_BLE, OP_BGE, OP_JUMP, 7'h7F};
        tbl[0]  = '{OP_ADD,  5'd3,  5'd4,  15'h1400, 1, 5'd3,  5'd4,  5'd5,  32'h0,       0};
        tbl[1]  = '{OP_SUB,  5'd31, 5'd1,  15'h7C00, 1, 5'd31, 5'd1,  5'd31, 32'h0,       0};
        tbl[2]  = '{OP_MUL,  5'd7,  5'd8,  15'h2400, 1, 5'd7,  5'd8,  5'd9,  32'h0,       0};
        tbl[3]  = '{OP_ADDI, 5'd1,  5'd0,  15'h7FFF, 1, 5'd1,  5'd0,  5'd0,  32'h7FFF,    0};
        tbl[4]  = '{OP_LDB,  5'd2,  5'd3,  15'h0123, 1, 5'd2,  5'd3,  5'd0,  32'h123,     0};
        tbl[5]  = '{OP_LDW,  5'd4,  5'd5,  15'h4000, 1, 5'd4,  5'd5,  5'd0,  32'h4000,    0};
        tbl[6]  = '{OP_STB,  5'd6,  5'd7,  15'h0010, 1, 5'd0,  5'd6,  5'd7,  32'h10,      0};
        tbl[7]  = '{OP_STW,  5'd9,  5'd10, 15'h0001, 1, 5'd0,  5'd9,  5'd10, 32'h1,       0};
        tbl[8]  = '{OP_BEQ,  5'd1,  5'd2,  15'h7FFF, 1, 5'd0,  5'd1,  5'd2,  32'h7FFF,    0};
        tbl[9]  = '{OP_BGE,  5'd3,  5'd4,  15'h0008, 1, 5'd0,  5'd3,  5'd4,  32'h8,       0};
        tbl[10] = '{OP_JUMP, 5'd31, 5'd31, 15'h7FFF, 1, 5'd0,  5'd0,  5'd0,  32'h1FFFFFF, 0};
        tbl[11] = '{7'h7F,   5'd1,  5'd2,  15'h0003, 0, 5'd0,  5'd0,  5'd0,  32'h0,       1};
        tbl[12] = '{7'h20,   5'd5,  5'd6,  15'h0007, 0, 5'd0,  5'd0,  5'd0,  32'h0,       1};
        idle();
        #2;
        for (int k = 0; k < 13; k++) begin
            idle();
            do_reset();
            pc = 32'h100 + 32'(k) * 4;
            fetch({tbl[k].op, tbl[k].f1, tbl[k].f2, tbl[k].f3}, pc);
            step("tbl");
            chk("tbl.v", bus.req_alu_valid, tbl[k].v);
            chk("tbl.rd", bus.req_alu_rd_addr, tbl[k].rd);
            chk("tbl.ra", bus.req_alu_ra_addr, tbl[k].ra);
            chk("tbl.rb", bus.req_alu_rb_addr, tbl[k].rb);
            chk("tbl.off", bus.req_alu_offset, tbl[k].off);
            chk("tbl.pc", bus.req_alu_pc, tbl[k].x ? 32'd0 : pc);
            chk("tbl.x", bus.xcpt_illegal, tbl[k].x);
            chk("tbl.xpc", bus.xcpt_pc, tbl[k].x ? pc : 32'd0);
        end

        idle();
        do_reset();
        fetch({OP_ADDI, 5'd1, 5'd0, 15'd5}, 32'h10);
        step("addi");
        chk("addi.valid", bus.req_alu_valid, 1);
        chk("addi.rd", bus.req_alu_rd_addr, 1);
        chk("addi.ra_data", bus.req_alu_ra_data, 0);
        chk("addi.off", bus.req_alu_offset, 5);
        fetch({OP_ADD, 5'd2, 5'd1, 5'd1, 10'd0}, 32'h14);
        #1 chk("raw.busy", bus.decode_busy, 1);
        step("raw");
        chk("raw.bubble", bus.req_alu_valid, 0);
        step("raw");
        bus.rf_wr_en = 1; bus.rf_wr_addr = 1; bus.rf_wr_data = 5;
        #1 chk("raw.wb_busy", bus.decode_busy, 0);
        step("raw");
        bus.rf_wr_en = 0;
        chk("raw.valid", bus.req_alu_valid, 1);
        chk("raw.rd", bus.req_alu_rd_addr, 2);
        chk("raw.ra_data", bus.req_alu_ra_data, 5);
        chk("raw.rb_data", bus.req_alu_rb_data, 5);

        fetch({OP_ADDI, 5'd5, 5'd0, 15'd7}, 32'h18);
        bus.stall_decode = 1;
        for (int c = 0; c < 3; c++) begin
            step("stall");
            chk("stall.valid", bus.req_alu_valid, 1);
            chk("stall.rd", bus.req_alu_rd_addr, 2);
        end
        bus.stall_decode = 0;
        step("stall");
        chk("stall.rel_rd", bus.req_alu_rd_addr, 5);
        chk("stall.rel_off", bus.req_alu_offset, 7);

        fetch({OP_ADDI, 5'd6, 5'd0, 15'd1}, 32'h1C);
        bus.stall_decode = 1; bus.flush_decode = 1;
        step("flush");
        chk("flush.valid", bus.req_alu_valid, 0);
        bus.stall_decode = 0; bus.flush_decode = 0;
        fetch({OP_ADD, 5'd7, 5'd6, 5'd6, 10'd0}, 32'h20);
        #1 chk("flush.nopend", bus.decode_busy, 0);
        step("flush");
        chk("flush.next", bus.req_alu_rd_addr, 7);

        fetch({7'h7F, 25'd0}, 32'h40);
        step("ill");
        chk("ill.x", bus.xcpt_illegal, 1);
        chk("ill.xpc", bus.xcpt_pc, 32'h40);
        chk("ill.valid", bus.req_alu_valid, 0);
        idle();
        step("ill");
        chk("ill.once", bus.xcpt_illegal, 0);

        fetch({OP_ADDI, 5'd3, 5'd0, 15'd9}, 32'h50);
        step("rst3");
        fetch({OP_ADD, 5'd4, 5'd3, 5'd3, 10'd0}, 32'h54);
        bus.stall_decode = 1;
        step("rst3");
        step("rst3");
        #2;
        do_reset();
        chk("rst3.valid", bus.req_alu_valid, 0);
        bus.stall_decode = 0;
        #1 chk("rst3.nohaz", bus.decode_busy, 0);
        step("rst3");
        chk("rst3.acc", bus.req_alu_rd_addr, 4);

        idle();
        do_reset();
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!hold) begin
                bus.fetch_valid = $urandom_range(0, 9) < 8;
                bus.fetch_instr = {ops[$urandom_range(0, 15)], 5'($urandom_range(0, 7)),
                                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                   10'($urandom)};
                bus.fetch_pc = $urandom & 32'hFFFFFFFC;
            end
            bus.stall_decode = $urandom_range(0, 9) == 0;
            bus.flush_decode = $urandom_range(0, 19) == 0;
            bus.rf_wr_en = $urandom_range(0, 9) < 3;
            bus.rf_wr_addr = 5'($urandom_range(0, 7));
            bus.rf_wr_data = $urandom;
            step("rnd");
            hold = m_busy && bus.fetch_valid && !bus.flush_decode;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
